// File: rtl/modport_core.sv
// modport_core: stride-1, zero-padded, same-size 2D convolution core.
// Feature map and weights live in internal memories loaded over a paired
// address/data handshake; a start pulse streams one MAC per cycle and emits
// each saturated result with its (x, y, output channel) coordinates.
// Optional macro RELU_EN: negative saturated results are clamped to zero.
module modport_core #(
  parameter int DATA_WIDTH         = 16,
  parameter int FEATURE_MAP_WIDTH  = 8,
  parameter int FEATURE_MAP_HEIGHT = 8,
  parameter int INPUT_NB_CHANNELS  = 2,
  parameter int OUTPUT_NB_CHANNELS = 4,
  parameter int KERNEL_SIZE        = 3,
  parameter int OUTPUT_SHIFT       = 0
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  int_mem_we,
  input  logic [DATA_WIDTH-1:0]                 a_input,
  input  logic                                  a_valid,
  output logic                                  a_ready,
  input  logic [DATA_WIDTH-1:0]                 b_input,
  input  logic                                  b_valid,
  output logic                                  b_ready,
  input  logic                                  start,
  output logic                                  running,
  output logic [DATA_WIDTH-1:0]                 output_data,
  output logic                                  output_valid,
  output logic [$clog2(FEATURE_MAP_WIDTH)-1:0]  output_x,
  output logic [$clog2(FEATURE_MAP_HEIGHT)-1:0] output_y,
  output logic [$clog2(OUTPUT_NB_CHANNELS)-1:0] output_ch
);

  localparam int DW       = DATA_WIDTH;
  localparam int W        = FEATURE_MAP_WIDTH;
  localparam int H        = FEATURE_MAP_HEIGHT;
  localparam int CIN      = INPUT_NB_CHANNELS;
  localparam int COUT     = OUTPUT_NB_CHANNELS;
  localparam int K        = KERNEL_SIZE;
  localparam int P        = (K - 1) / 2;
  localparam int FM_WORDS = W * H * CIN;
  localparam int WT_WORDS = COUT * CIN * K * K;
  localparam int XW       = $clog2(W);
  localparam int YW       = $clog2(H);
  localparam int CW       = $clog2(COUT);
  localparam int IW       = (CIN > 1) ? $clog2(CIN) : 1;
  localparam int KW       = (K > 1) ? $clog2(K) : 1;
  localparam int FAW      = $clog2(FM_WORDS);
  localparam int WAW      = $clog2(WT_WORDS);
  localparam int ACC_W    = 2 * DW + $clog2(K * K * CIN);

  localparam logic signed [ACC_W-1:0] SAT_MAX = $signed({{(ACC_W-DW+1){1'b0}}, {(DW-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = $signed({{(ACC_W-DW+1){1'b1}}, {(DW-1){1'b0}}});

  typedef enum logic {IDLE, RUN} state_t;

  // Side-band travelling with each tap through the one-cycle read stage
  typedef struct packed {
    logic          first;
    logic          last;
    logic          pad;
    logic          pt_last;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [CW-1:0] co;
  } tag_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        co;
  logic [YW-1:0]        y;
  logic [XW-1:0]        x;
  logic [IW-1:0]        ci;
  logic [KW-1:0]        ky, kx;
  logic                 wb, done, issue;
  logic                 tap_first, tap_last, pt_last;
  int                   iy, ix;
  logic                 pad;
  logic [FAW-1:0]       f_addr;
  logic [WAW-1:0]       w_addr;
  logic signed [DW-1:0] fmem [FM_WORDS];
  logic signed [DW-1:0] wmem [WT_WORDS];
  logic signed [DW-1:0] f_q, w_q;
  logic [31:0]          a_ext;
  logic                 wr_en, fm_we, wt_we;
  tag_t                 tag_d, tag_q;
  logic [1:0]           vld_pipe;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] prod_ext, acc, acc_nxt, acc_sh;
  logic signed [DW-1:0] res;
  logic                 out_last;

  assign running      = (state == RUN);
  assign output_valid = vld_pipe[1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state and load handshake; ready never looks at the valids
  always_comb begin
    state_nxt = state;
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    case (state)
      IDLE: begin
        a_ready = int_mem_we;
        b_ready = int_mem_we;
        if (start && !int_mem_we) state_nxt = RUN;
      end
      RUN: begin
        // Leave only once the final result strobe has been presented
        if (output_valid && out_last) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Write decode: out-of-range addresses are acknowledged but dropped
  assign a_ext = 32'(a_input);
  assign wr_en = a_valid & a_ready & b_valid & b_ready;
  assign fm_we = wr_en && (a_ext < 32'(FM_WORDS));
  assign wt_we = wr_en && (a_ext >= 32'(FM_WORDS)) && (a_ext < 32'(FM_WORDS + WT_WORDS));

  assign tap_first = (ci == '0) && (ky == '0) && (kx == '0);
  assign tap_last  = (ci == IW'(CIN-1)) && (ky == KW'(K-1)) && (kx == KW'(K-1));
  assign pt_last   = (co == CW'(COUT-1)) && (y == YW'(H-1)) && (x == XW'(W-1));
  assign issue     = (state == RUN) && !done && !wb;

  // Loop counters: co, y, x outer; ci, ky, kx inner; one idle slot per point
  always_ff @(posedge clk) begin
    if (rst || state != RUN) begin
      co <= '0; y <= '0; x <= '0; ci <= '0; ky <= '0; kx <= '0;
      wb <= 1'b0; done <= 1'b0;
    end else if (!done) begin
      if (wb) begin
        wb <= 1'b0;
        if (x == XW'(W-1)) begin
          x <= '0;
          if (y == YW'(H-1)) begin
            y  <= '0;
            co <= co + 1'b1;
          end else begin
            y <= y + 1'b1;
          end
        end else begin
          x <= x + 1'b1;
        end
      end else if (tap_last) begin
        ci <= '0; ky <= '0; kx <= '0;
        if (pt_last) done <= 1'b1;
        else         wb   <= 1'b1;
      end else if (kx == KW'(K-1)) begin
        kx <= '0;
        if (ky == KW'(K-1)) begin
          ky <= '0;
          ci <= ci + 1'b1;
        end else begin
          ky <= ky + 1'b1;
        end
      end else begin
        kx <= kx + 1'b1;
      end
    end
  end

  // Tap addressing; padded taps read word 0 and are masked at the MAC
  always_comb begin
    iy     = int'(y) + int'(ky) - P;
    ix     = int'(x) + int'(kx) - P;
    pad    = (iy < 0) || (iy >= H) || (ix < 0) || (ix >= W);
    f_addr = pad ? '0 : FAW'((int'(ci) * H + iy) * W + ix);
    w_addr = WAW'(((int'(co) * CIN + int'(ci)) * K + int'(ky)) * K + int'(kx));
    tag_d  = '{first: tap_first, last: tap_last, pad: pad, pt_last: pt_last,
               x: x, y: y, co: co};
  end

  // Feature memory: load writes, synchronous run-time read
  always_ff @(posedge clk) begin
    if (fm_we) fmem[FAW'(a_ext)] <= b_input;
    f_q <= fmem[f_addr];
  end

  // Weight memory: load writes, synchronous run-time read
  always_ff @(posedge clk) begin
    if (wt_we) wmem[WAW'(a_ext - 32'(FM_WORDS))] <= b_input;
    w_q <= wmem[w_addr];
  end

  // Tag follows the read data by one cycle
  always_ff @(posedge clk) begin
    tag_q <= tag_d;
  end

  // MAC, shift, saturate (and optional clamp of negatives)
  always_comb begin
    prod     = f_q * w_q;
    prod_ext = tag_q.pad ? '0 : $signed({{(ACC_W-2*DW){prod[2*DW-1]}}, prod});
    acc_nxt  = (tag_q.first ? '0 : acc) + prod_ext;
    acc_sh   = acc_nxt >>> OUTPUT_SHIFT;
    if (acc_sh > SAT_MAX)      res = {1'b0, {(DW-1){1'b1}}};
    else if (acc_sh < SAT_MIN) res = {1'b1, {(DW-1){1'b0}}};
    else                       res = acc_sh[DW-1:0];
`ifdef RELU_EN
    if (res[DW-1]) res = '0;
`else
`endif
  end

  // Accumulate and register the result on the last tap of each point
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe    <= '0;
      acc         <= '0;
      output_data <= '0;
      output_x    <= '0;
      output_y    <= '0;
      output_ch   <= '0;
      out_last    <= 1'b0;
    end else begin
      vld_pipe <= {vld_pipe[0] & tag_q.last, issue};
      if (vld_pipe[0]) acc <= acc_nxt;
      if (vld_pipe[0] && tag_q.last) begin
        output_data <= res;
        output_x    <= tag_q.x;
        output_y    <= tag_q.y;
        output_ch   <= tag_q.co;
        out_last    <= tag_q.pt_last;
      end
    end
  end

endmodule

// File: tb/tb_modport_core.sv
// Directed bench for modport_core: loads memories over the handshake,
// runs full convolutions and checks every result, its coordinates and timing.
module tb_modport_core;
  localparam int DW = 16, W = 8, H = 8, CIN = 2, COUT = 4, K = 3;
  localparam int NPT = W * H * COUT, TAPS = K * K * CIN;
  localparam int FMW = W * H * CIN, WTW = COUT * CIN * K * K;
  localparam int XW = $clog2(W), YW = $clog2(H), CW = $clog2(COUT);
  localparam int PW = DW + XW + YW + CW;

  logic clk = 0, rst = 0, int_mem_we = 0, a_valid = 0, b_valid = 0, start = 0;
  logic [DW-1:0] a_input = '0, b_input = '0;
  logic a_ready, b_ready, running, output_valid;
  logic [DW-1:0] output_data;
  logic [XW-1:0] output_x;
  logic [YW-1:0] output_y;
  logic [CW-1:0] output_ch;

  modport_core dut (
    .clk(clk), .rst(rst), .int_mem_we(int_mem_we),
    .a_input(a_input), .a_valid(a_valid), .a_ready(a_ready),
    .b_input(b_input), .b_valid(b_valid), .b_ready(b_ready),
    .start(start), .running(running),
    .output_data(output_data), .output_valid(output_valid),
    .output_x(output_x), .output_y(output_y), .output_ch(output_ch)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_err = 0;
  logic signed [DW-1:0] fm_img [CIN][H][W];
  logic signed [DW-1:0] wt_img [COUT][CIN][K][K];
  logic [PW-1:0] got_pt [NPT];
  int  got_cyc [NPT];
  int  got_cnt, start_cyc, fall_cyc, extra_cnt;
  bit  first_hi, rdy_seen, tmo;

  // Reference convolution over the bench's own memory image
  function automatic logic signed [DW-1:0] ref_out(int co, int y, int x);
    longint acc = 0;
    int iy, ix;
    for (int ci = 0; ci < CIN; ci++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++) begin
          iy = y + ky - (K - 1) / 2;
          ix = x + kx - (K - 1) / 2;
          if (iy >= 0 && iy < H && ix >= 0 && ix < W)
            acc += longint'(fm_img[ci][iy][ix]) * longint'(wt_img[co][ci][ky][kx]);
        end
    if (acc > 32767) acc = 32767;
    else if (acc < -32768) acc = -32768;
`ifdef RELU_EN
    if (acc < 0) acc = 0;
`else
`endif
    return 16'(acc);
  endfunction

  function automatic logic [PW-1:0] exp_pt(int i);
    return {ref_out(i / (W * H), (i / W) % H, i % W), XW'(i % W), YW'((i / W) % H), CW'(i / (W * H))};
  endfunction

  task automatic wr(input int addr, input logic [DW-1:0] d);
    int a;
    @(negedge clk);
    int_mem_we = 1; a_valid = 1; b_valid = 1; a_input = 16'(addr); b_input = d;
    @(negedge clk);
    a_valid = 0; b_valid = 0;
    if (addr < FMW) fm_img[addr / (W * H)][(addr / W) % H][addr % W] = d;
    else if (addr < FMW + WTW) begin
      a = addr - FMW;
      wt_img[a / (CIN * K * K)][(a / (K * K)) % CIN][(a / K) % K][a % K] = d;
    end
  endtask

  task automatic load_uniform(input logic [DW-1:0] f, input logic [DW-1:0] w);
    for (int a = 0; a < FMW + WTW; a++) wr(a, (a < FMW) ? f : w);
    int_mem_we = 0;
  endtask

  // Starts a run and records every result strobe until running drops
  task automatic run_collect(input bit noisy);
    got_cnt = 0; fall_cyc = -1; extra_cnt = 0; tmo = 0; rdy_seen = 0;
    for (int i = 0; i < NPT; i++) got_pt[i] = 'x;
    @(negedge clk);
    int_mem_we = 0; start = 1;
    @(negedge clk);
    if (!noisy) start = 0;
    start_cyc = cyc; first_hi = running;
    for (int i = 0; i < 8000 && fall_cyc < 0; i++) begin
      if (noisy && i == 5) begin
        int_mem_we = 1; a_valid = 1; b_valid = 1; a_input = 16'd0; b_input = 16'h1234;
        #1;
      end
      if (noisy && i == 200) begin
        start = 0; int_mem_we = 0; a_valid = 0; b_valid = 0;
      end
      if (a_ready || b_ready) rdy_seen = 1;
      if (output_valid) begin
        if (got_cnt < NPT) begin
          got_pt[got_cnt]  = {output_data, output_x, output_y, output_ch};
          got_cyc[got_cnt] = cyc;
        end
        got_cnt++;
      end
      if (!running) fall_cyc = cyc;
      else @(negedge clk);
    end
    if (fall_cyc < 0) tmo = 1;
    repeat (40) begin
      @(negedge clk);
      if (output_valid || running) extra_cnt++;
    end
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({running, output_valid, a_ready, b_ready} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags got %b exp 0000", {running, output_valid, a_ready, b_ready});
    end
    n_cmp++;
    if ({output_data, output_x, output_y, output_ch} !== '0) begin
      n_err++; $display("FAIL reset_outs got %h exp 0", {output_data, output_x, output_y, output_ch});
    end
    rst = 0;
    @(negedge clk);
    n_cmp++;
    if ({running, output_valid} !== 2'b00) begin
      n_err++; $display("FAIL reset_idle got %b exp 00", {running, output_valid});
    end
  endtask

  task automatic test_ones;
    int nr, nc, bad;
    logic [PW-1:0] e;
    load_uniform(16'd1, 16'd1);
    run_collect(0);
    n_cmp++;
    if (tmo !== 0 || got_cnt !== NPT) begin
      n_err++; $display("FAIL ones_count got %0d (timeout %0d) exp %0d", got_cnt, tmo, NPT);
    end
    n_cmp++;
    if (first_hi !== 1'b1) begin n_err++; $display("FAIL ones_running_rise got %b exp 1", first_hi); end
    for (int i = 0; i < NPT; i++) begin
      nr = (((i / W) % H) == 0 || ((i / W) % H) == H - 1) ? 2 : 3;
      nc = ((i % W) == 0 || (i % W) == W - 1) ? 2 : 3;
      e = {16'(nr * nc * CIN), XW'(i % W), YW'((i / W) % H), CW'(i / (W * H))};
      n_cmp++;
      if (got_pt[i] !== e) begin n_err++; $display("FAIL ones_pt%0d got %h exp %h", i, got_pt[i], e); end
    end
    n_cmp++;
    if (got_cyc[0] - start_cyc < 1 || got_cyc[0] - start_cyc > TAPS + 3) begin
      n_err++; $display("FAIL ones_latency got %0d exp <= %0d", got_cyc[0] - start_cyc, TAPS + 3);
    end
    bad = 0;
    for (int i = 1; i < NPT; i++) if (got_cyc[i] - got_cyc[i-1] != TAPS + 1) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL ones_interval got %0d bad gaps exp 0", bad); end
    n_cmp++;
    if (fall_cyc !== got_cyc[NPT-1] + 1) begin
      n_err++; $display("FAIL ones_running_fall got %0d exp %0d", fall_cyc, got_cyc[NPT-1] + 1);
    end
    n_cmp++;
    if (extra_cnt !== 0 || rdy_seen !== 0) begin
      n_err++; $display("FAIL ones_after got extra %0d ready %0d exp 0 0", extra_cnt, rdy_seen);
    end
  endtask

  task automatic test_handshake;
    @(negedge clk);
    int_mem_we = 0; a_valid = 1; b_valid = 1; a_input = 16'd5; b_input = 16'd77;
    #1;
    n_cmp++;
    if ({a_ready, b_ready} !== 2'b00) begin
      n_err++; $display("FAIL hs_ready_we_low got %b exp 00", {a_ready, b_ready});
    end
    @(negedge clk);
    int_mem_we = 1; b_valid = 0; a_input = 16'd0; b_input = 16'd50;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_cmp++;
      if ({a_ready, b_ready} !== 2'b11) begin
        n_err++; $display("FAIL hs_ready_lone%0d got %b exp 11", i, {a_ready, b_ready});
      end
      @(negedge clk);
    end
    a_input = 16'd36; b_input = 16'd3; b_valid = 1;
    @(negedge clk);
    a_valid = 0; fm_img[0][4][4] = 3;
    a_input = 16'd82; b_input = 16'd50;
    repeat (3) @(negedge clk);
    b_valid = 0;
    wr(FMW + WTW, 16'd99);
    wr(65535, 16'd99);
    int_mem_we = 0;
    run_collect(0);
    n_cmp++;
    if (got_cnt !== NPT) begin n_err++; $display("FAIL hs_count got %0d exp %0d", got_cnt, NPT); end
    for (int i = 0; i < NPT; i++) begin
      n_cmp++;
      if (got_pt[i] !== exp_pt(i)) begin n_err++; $display("FAIL hs_pt%0d got %h exp %h", i, got_pt[i], exp_pt(i)); end
    end
  endtask

  task automatic test_mid_reset;
    int bad;
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    repeat (50) @(negedge clk);
    rst = 1;
    @(negedge clk);
    n_cmp++;
    if ({running, output_valid} !== 2'b00) begin
      n_err++; $display("FAIL mr_edge got %b exp 00", {running, output_valid});
    end
    n_cmp++;
    if (output_data !== '0) begin n_err++; $display("FAIL mr_data got %h exp 0", output_data); end
    rst = 0; bad = 0;
    repeat (40) begin
      @(negedge clk);
      if (running || output_valid) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL mr_quiet got %0d active cycles exp 0", bad); end
    run_collect(0);
    n_cmp++;
    if (got_cnt !== NPT) begin n_err++; $display("FAIL mr_count got %0d exp %0d", got_cnt, NPT); end
    for (int i = 0; i < NPT; i++) begin
      n_cmp++;
      if (got_pt[i] !== exp_pt(i)) begin n_err++; $display("FAIL mr_pt%0d got %h exp %h", i, got_pt[i], exp_pt(i)); end
    end
  endtask

  task automatic test_start_ignored;
    int bad;
    bad = 0;
    @(negedge clk);
    int_mem_we = 1; start = 1;
    repeat (4) begin
      @(negedge clk);
      if (running) bad++;
    end
    start = 0; int_mem_we = 0;
    @(negedge clk);
    if (running) bad++;
    n_cmp++;
    if (bad !== 0) begin n_err++; $display("FAIL si_we_start got %0d running cycles exp 0", bad); end
    run_collect(1);
    n_cmp++;
    if (got_cnt !== NPT || extra_cnt !== 0) begin
      n_err++; $display("FAIL si_count got %0d extra %0d exp %0d 0", got_cnt, extra_cnt, NPT);
    end
    n_cmp++;
    if (rdy_seen !== 0) begin n_err++; $display("FAIL si_ready_run got %b exp 0", rdy_seen); end
    for (int i = 0; i < NPT; i++) begin
      n_cmp++;
      if (got_pt[i] !== exp_pt(i)) begin n_err++; $display("FAIL si_pt%0d got %h exp %h", i, got_pt[i], exp_pt(i)); end
    end
  endtask

  task automatic test_values;
    logic [DW-1:0] tf [4];
    logic [DW-1:0] tw [4];
    int ti [4];
    logic [PW-1:0] e;
    tf = '{16'h0001, 16'h0001, 16'h7FFF, 16'h7FFF};
    tw = '{16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000};
`ifdef RELU_EN
    ti = '{18, 0, 32767, 0};
`else
    ti = '{18, -18, 32767, -32768};
`endif
    for (int t = 0; t < 4; t++) begin
      load_uniform(tf[t], tw[t]);
      run_collect(0);
      n_cmp++;
      if (got_cnt !== NPT) begin n_err++; $display("FAIL val%0d_count got %0d exp %0d", t, got_cnt, NPT); end
      e = {16'(ti[t]), XW'(1), YW'(1), CW'(0)};
      n_cmp++;
      if (got_pt[W + 1] !== e) begin n_err++; $display("FAIL val%0d_interior got %h exp %h", t, got_pt[W + 1], e); end
      for (int i = 0; i < NPT; i++) begin
        n_cmp++;
        if (got_pt[i] !== exp_pt(i)) begin n_err++; $display("FAIL val%0d_pt%0d got %h exp %h", t, i, got_pt[i], exp_pt(i)); end
      end
    end
  endtask

  task automatic test_pattern;
    int a;
    for (int ci = 0; ci < CIN; ci++)
      for (int y = 0; y < H; y++)
        for (int x = 0; x < W; x++)
          wr((ci * H + y) * W + x, 16'(ci * 50 + y * 8 + x - 30));
    for (int co = 0; co < COUT; co++)
      for (int ci = 0; ci < CIN; ci++)
        for (int k = 0; k < K * K; k++) begin
          a = FMW + (co * CIN + ci) * K * K + k;
          wr(a, 16'(k - 4 + ci * 9 - co * 2));
        end
    int_mem_we = 0;
    run_collect(0);
    n_cmp++;
    if (got_cnt !== NPT) begin n_err++; $display("FAIL pat_count got %0d exp %0d", got_cnt, NPT); end
    for (int i = 0; i < NPT; i++) begin
      n_cmp++;
      if (got_pt[i] !== exp_pt(i)) begin n_err++; $display("FAIL pat_pt%0d got %h exp %h", i, got_pt[i], exp_pt(i)); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_handshake();
    test_mid_reset();
    test_start_ignored();
    test_values();
    test_pattern();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/modport_core.md
Name: modport_core

Overview:
- Stand-alone 2D convolution accelerator core, driven over a clocking-block interface by the chip-level testbench.
- Internal memories hold the input feature map and the kernel weights, loaded word by word over paired address (a) / data (b) handshake channels.
- After a start pulse it computes a stride-1, zero-padded, same-size convolution with one MAC per cycle.
- It streams each result with its (x, y, output-channel) coordinates.

Parameters:
- DATA_WIDTH, 16: width of feature, weight, address and output words (signed two's complement).
- FEATURE_MAP_WIDTH, 8: W, columns of input and output map.
- FEATURE_MAP_HEIGHT, 8: H, rows of input and output map.
- INPUT_NB_CHANNELS, 2: Cin.
- OUTPUT_NB_CHANNELS, 4: Cout.
- KERNEL_SIZE, 3: K, odd; padding is (K-1)/2.
- OUTPUT_SHIFT, 0: arithmetic right shift applied to the accumulator before saturation.

Ports:
- clk  in  1  single clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- int_mem_we  in  1  load mode; memory writes are accepted only while high.
- a_input  in  DATA_WIDTH  write address.
- a_valid  in  1  address valid.
- a_ready  out  1  address accepted.
- b_input  in  DATA_WIDTH  write data (signed).
- b_valid  in  1  data valid.
- b_ready  out  1  data accepted.
- start  in  1  begin computation.
- running  out  1  computation in progress.
- output_data  out  DATA_WIDTH  signed result.
- output_valid  out  1  one-cycle result strobe; there is no back-pressure.
- output_x  out  clog2(W)  result column.
- output_y  out  clog2(H)  result row.
- output_ch  out  clog2(Cout)  result output channel.

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset state:
  - State is IDLE.
  - running, output_valid, a_ready, b_ready, output_data, output_x, output_y and output_ch are all 0.
  - Memory contents are not cleared.
- States: IDLE, RUN.
- IDLE behaviour:
  - a_ready = b_ready = int_mem_we. These depend only on registered state and int_mem_we, never on the valids.
  - A write occurs on an edge where a_valid & a_ready & b_valid & b_ready are all high.
  - A lone valid on one channel does not complete a write.
- Memory address map:
  - Feature word (ci, y, x) is at address (ci*H + y)*W + x.
  - Weight word (co, ci, ky, kx) is at address W*H*Cin + ((co*Cin + ci)*K + ky)*K + kx.
  - Addresses at or beyond W*H*Cin + Cout*Cin*K*K are acknowledged and discarded.
- Start:
  - start sampled high in IDLE with int_mem_we low moves the core to RUN; running goes high on the next cycle.
  - start is ignored while int_mem_we is high, and ignored in RUN.
- RUN behaviour:
  - a_ready = b_ready = 0.
  - Iteration order, outer to inner: co, y, x, then ci, ky, kx.
  - Each output point takes exactly K*K*Cin MAC cycles plus 1 writeback cycle.
  - Taps whose input coordinate falls outside the map contribute 0 but still consume their cycle.
- Arithmetic:
  - Products are signed DATA_WIDTH x DATA_WIDTH.
  - The accumulator is 2*DATA_WIDTH + clog2(K*K*Cin) bits, so it never overflows.
  - Result = accumulator >>> OUTPUT_SHIFT, then saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1].
- Result output:
  - output_valid pulses for one cycle per point, with x, y and ch valid in the same cycle.
  - The first pulse occurs at most K*K*Cin+3 cycles after start is sampled.
  - Consecutive pulses are exactly K*K*Cin+1 cycles apart.
- Completion: running falls on the cycle after the last result (co=Cout-1, y=H-1, x=W-1), and the core returns to IDLE.
- rst asserted mid-run: the next edge forces IDLE, and running and output_valid are 0 from then on. Stored memory is kept.
- Memory reads are synchronous, one cycle; the read pipeline is absorbed in the latency bound above.

Optional Feature:
- Macro RELU_EN.
- When defined: a negative saturated result is output as 0; positive results are unchanged.
- When undefined: the signed saturated result is output as is.

Test Plan:
- All features = 1 and all weights = 1, then start → 256 outputs in co/y/x order. Values: 18 interior, 12 on edges, 8 at corners. Pulses every 19 cycles; running low afterwards.
- All weights = -1 and features = 1 → interior -18 without RELU_EN, 0 with RELU_EN.
- Features = 0x7FFF and weights = 0x7FFF → every output 32767, saturated positive. Weights = 0x8000 → -32768, or 0 with RELU_EN.
- a_valid=1 with b_valid=0 for 5 cycles, then both high → exactly one write. a_ready and b_ready are 0 while int_mem_we=0 and during RUN.
- rst pulsed 50 cycles into RUN → running=0 and no output_valid after the reset edge. A subsequent start reproduces the full correct result set from the retained memory.
- start held high during RUN, and start asserted with int_mem_we=1 → both ignored; the output count stays exactly 256.
